// File: rtl/muskbus_line_writer.sv
// Writes one 64-byte cache line to memory over MUSKBUS.
// The transfer is one address beat tagged WRITE_MEM_TAG followed by eight data beats.

package MUSKBUS;
   localparam logic [7:0] READ_MEM_TAG  = 8'h01;
   localparam logic [7:0] WRITE_MEM_TAG = 8'h02;

   typedef struct packed {
      logic        bid;
      logic        reqcyc;
      logic [7:0]  reqtag;
      logic [63:0] req;
   } req_t;

   typedef struct packed {
      logic        respcyc;
      logic [7:0]  resptag;
      logic [63:0] resp;
      logic        reqack;
   } resp_t;
endpackage

module muskbus_line_writer
   import MUSKBUS::*;
#(
   parameter int LINE_BITS = 512,
   parameter int BEAT_BITS = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   output req_t                 bus_req,
   output logic                 bus_respack,
   input  resp_t                bus_resp,
   input  logic                 reqcyc,
   input  logic [63:0]          addr,
   input  logic [0:LINE_BITS-1] data,
   output logic                 busy,
   output logic                 respcyc
);

   localparam int NBEATS   = LINE_BITS / BEAT_BITS;
   localparam int CNT_BITS = $clog2(NBEATS);
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(NBEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                 state;
   state_t                 next_state;
   logic [CNT_BITS-1:0]    beat_cnt;
   logic [63:0]            addr_q;
   logic [0:LINE_BITS-1]   line_q;
   logic [BEAT_BITS-1:0]   beat_word;

   wire unused_inputs = &{1'b0, bus_resp.respcyc, bus_resp.resptag,
                          bus_resp.resp, addr[5:0]};

   // The line is captured at accept so the client may reuse its buffer at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         beat_cnt <= '0;
         addr_q   <= '0;
         line_q   <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && reqcyc) begin
            addr_q <= {addr[63:6], 6'b0};
            line_q <= data;
         end
         if (state == ADDR && bus_resp.reqack) begin
            beat_cnt <= '0;
         end else if (state == DATA && bus_resp.reqack && beat_cnt != LAST_BEAT) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      beat_word = '0;
      for (int i = 0; i < NBEATS; i++) begin
         if (beat_cnt == CNT_BITS'(i)) begin
            beat_word = line_q[i*BEAT_BITS +: BEAT_BITS];
         end
      end
   end

   // Request fields are only driven while bidding, so reqcyc never appears without bid.
   always_comb begin
      next_state  = state;
      bus_req     = '0;
      bus_respack = 1'b0;
      busy        = 1'b1;
      respcyc     = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (reqcyc) begin
               next_state = ADDR;
            end
         end
         ADDR: begin
            bus_req.bid    = 1'b1;
            bus_req.reqcyc = 1'b1;
            bus_req.reqtag = WRITE_MEM_TAG;
            bus_req.req    = addr_q;
            if (bus_resp.reqack) begin
               next_state = DATA;
            end
         end
         DATA: begin
            bus_req.bid    = 1'b1;
            bus_req.reqcyc = 1'b1;
            bus_req.reqtag = WRITE_MEM_TAG;
            bus_req.req    = beat_word;
            if (bus_resp.reqack && beat_cnt == LAST_BEAT) begin
               next_state = DONE;
            end
         end
         DONE: begin
            respcyc    = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_muskbus_line_writer.sv
// Directed self-checking bench for muskbus_line_writer.
// Covers reset, full-rate lines, stalls, a held request, mid-transfer reset and latching.

module tb_muskbus_line_writer;
   import MUSKBUS::*;

   logic          clk;
   logic          reset;
   req_t          bus_req;
   logic          bus_respack;
   resp_t         bus_resp;
   logic          reqcyc;
   logic [63:0]   addr;
   logic [0:511]  data;
   logic          busy;
   logic          respcyc;

   int total = 0;
   int bad   = 0;

   muskbus_line_writer dut (
      .clk         (clk),
      .reset       (reset),
      .bus_req     (bus_req),
      .bus_respack (bus_respack),
      .bus_resp    (bus_resp),
      .reqcyc      (reqcyc),
      .addr        (addr),
      .data        (data),
      .busy        (busy),
      .respcyc     (respcyc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdleBus(input string tag);
      checkOutput({tag, "_bid"}, 64'(bus_req.bid), 64'd0);
      checkOutput({tag, "_reqcyc"}, 64'(bus_req.reqcyc), 64'd0);
      checkOutput({tag, "_respcyc"}, 64'(respcyc), 64'd0);
   endtask

   // One line: accept edge, then one check per bus cycle until DONE.
   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] base,
                                input int stallBeat, input int stallCycles,
                                input int expRespCycle, input logic holdReq,
                                input logic corrupt);
      int cyc;
      int pos;
      int stallLeft;
      logic [63:0] expWord;
      addr = a;
      for (int i = 0; i < 8; i++) data[i*64 +: 64] = base + 64'(i);
      reqcyc = 1'b1;
      bus_resp.reqack = 1'b1;
      tick();
      if (!holdReq) reqcyc = 1'b0;
      if (corrupt) begin
         addr = 64'hFFFF_FFFF_FFFF_FFFF;
         data = '1;
      end
      cyc = 2;
      pos = 0;
      stallLeft = stallCycles;
      while (pos <= 8 && cyc < 40) begin
         expWord = (pos == 0) ? {a[63:6], 6'b0} : base + 64'(pos - 1);
         checkOutput("beat_bid", 64'(bus_req.bid), 64'd1);
         checkOutput("beat_reqcyc", 64'(bus_req.reqcyc), 64'd1);
         checkOutput("beat_tag", 64'(bus_req.reqtag), 64'(WRITE_MEM_TAG));
         checkOutput("beat_req", bus_req.req, expWord);
         checkOutput("beat_respcyc", 64'(respcyc), 64'd0);
         checkOutput("beat_busy", 64'(busy), 64'd1);
         if (pos == stallBeat + 1 && stallLeft > 0) begin
            bus_resp.reqack = 1'b0;
            stallLeft--;
         end else begin
            bus_resp.reqack = 1'b1;
            pos++;
         end
         tick();
         cyc++;
      end
      checkOutput("resp_cycle", 64'(cyc), 64'(expRespCycle));
      checkOutput("done_respcyc", 64'(respcyc), 64'd1);
      checkOutput("done_bid", 64'(bus_req.bid), 64'd0);
      checkOutput("done_busy", 64'(busy), 64'd1);
      tick();
      checkOutput("idle_busy", 64'(busy), 64'd0);
      checkIdleBus("idle");
   endtask

   initial begin
      reset = 1'b0;
      reqcyc = 1'b0;
      addr = '0;
      data = '0;
      bus_resp = '0;
      #1;
      checkOutput("rst_busreq", 64'(bus_req.bid) | 64'(bus_req.reqcyc) | bus_req.req, 64'd0);
      checkOutput("rst_respack", 64'(bus_respack), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_respcyc", 64'(respcyc), 64'd0);
      tick();
      tick();
      reset = 1'b1;
      bus_resp.reqack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkIdleBus("post_reset");
         checkOutput("post_reset_busy", 64'(busy), 64'd0);
      end

      $display("[TB] full-rate line");
      applyStimulus(64'h1000_0047, 64'hA0, -1, 0, 11, 1'b0, 1'b0);

      $display("[TB] stall on beat 4");
      applyStimulus(64'h1000_0047, 64'hA0, 4, 3, 14, 1'b0, 1'b0);

      $display("[TB] reqcyc held across two lines");
      applyStimulus(64'h2000_0080, 64'hB0, -1, 0, 11, 1'b1, 1'b0);
      applyStimulus(64'h3000_00FF, 64'hC0, -1, 0, 11, 1'b1, 1'b0);
      reqcyc = 1'b0;
      tick();
      checkIdleBus("held_end");

      $display("[TB] reset during beat 2");
      addr = 64'h4000_0010;
      for (int i = 0; i < 8; i++) data[i*64 +: 64] = 64'hD0 + 64'(i);
      reqcyc = 1'b1;
      bus_resp.reqack = 1'b1;
      tick();
      reqcyc = 1'b0;
      tick();
      tick();
      tick();
      checkOutput("pre_abort_req", bus_req.req, 64'hD2);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("abort_bid", 64'(bus_req.bid), 64'd0);
      checkOutput("abort_req", bus_req.req, 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
      tick();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         checkIdleBus("after_abort");
         checkOutput("after_abort_busy", 64'(busy), 64'd0);
      end

      $display("[TB] client data changed after accept");
      applyStimulus(64'h5555_0000_1234_567F, 64'h1122_3344_5566_7700, -1, 0, 11, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
